// File: rtl/led_rate_sched_if.sv
// led_rate_sched_if: board-side pins of the LED rate sequencer (buttons in, pattern out).
// With LED_SCHED_HOLD_EN defined the bundle also carries the synchronous hold input.
interface led_rate_sched_if;
    logic       PB1;
    logic       PB2;
    logic [1:0] LED;
    logic [1:0] mode;
    logic [1:0] step;
    logic       tick;
`ifdef LED_SCHED_HOLD_EN
    logic       hold;

    modport master (output PB1, PB2, hold, input LED, mode, step, tick);
    modport slave  (input PB1, PB2, hold, output LED, mode, step, tick);
`else
    modport master (output PB1, PB2, input LED, mode, step, tick);
    modport slave  (input PB1, PB2, output LED, mode, step, tick);
`endif
endinterface

// File: rtl/led_rate_sched.sv
// led_rate_sched: debounced two-button IDLE/SLOW/FAST selector with step divider and LED pattern.
// Optional LED_SCHED_HOLD_EN adds a hold input that freezes the divider, step and LED.

module led_db #(
    parameter int DB_CYCLES = 1000000
) (
    input  logic clk,
    input  logic rst,
    input  logic pb,
    output logic press
);
    localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [CW-1:0] DB_LAST = CW'(DB_CYCLES - 1);

    logic          s1, s2, db, db_d;
    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1   <= 1'b1;
            s2   <= 1'b1;
            db   <= 1'b1;
            db_d <= 1'b1;
            cnt  <= '0;
        end else begin
            s1   <= pb;
            s2   <= s1;
            db_d <= db;
            if (s2 == db) begin
                cnt <= '0;
            end else if (cnt == DB_LAST) begin
                db  <= s2;
                cnt <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    // Falling debounced level only; releases are silent.
    assign press = db_d & ~db;
endmodule

module led_rate_sched #(
    parameter int SLOW_DIV  = 50000000,
    parameter int FAST_DIV  = 25000000,
    parameter int DB_CYCLES = 1000000
) (
    input  logic             clk,
    input  logic             rst,
    led_rate_sched_if.slave  io
);
    localparam int NUM_BTN = 2;
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] SLOW = 2'd1;
    localparam logic [1:0] FAST = 2'd2;
    localparam logic [30:0] SLOW_LAST = 31'(SLOW_DIV - 1);
    localparam logic [30:0] FAST_LAST = 31'(FAST_DIV - 1);

    logic [NUM_BTN-1:0] pb, press;
    logic [1:0]         mode, mode_nxt, step, step_inc, led;
    logic [30:0]        cnt, last;
    logic               tick, mode_chg, hold;

    assign pb = {io.PB2, io.PB1};

    genvar g;
    generate
        for (g = 0; g < NUM_BTN; g++) begin : g_btn
            led_db #(.DB_CYCLES(DB_CYCLES)) u_db (
                .clk   (clk),
                .rst   (rst),
                .pb    (pb[g]),
                .press (press[g])
            );
        end
    endgenerate

`ifdef LED_SCHED_HOLD_EN
    assign hold = io.hold;
`else
    assign hold = 1'b0;
`endif

    // PB1 has priority; a simultaneous PB2 event is dropped.
    always_comb begin
        mode_nxt = mode;
        if (press[0]) begin
            case (mode)
                IDLE:    mode_nxt = SLOW;
                SLOW:    mode_nxt = IDLE;
                default: mode_nxt = SLOW;
            endcase
        end else if (press[1]) begin
            case (mode)
                IDLE:    mode_nxt = FAST;
                SLOW:    mode_nxt = FAST;
                default: mode_nxt = IDLE;
            endcase
        end
    end

    assign mode_chg = |press;
    assign last     = (mode == FAST) ? FAST_LAST : SLOW_LAST;
    assign step_inc = step + 2'd1;

    function automatic logic [1:0] led_map(input logic fast, input logic [1:0] s);
        case (s)
            2'd1:    led_map = 2'b00;
            2'd2:    led_map = fast ? 2'b01 : 2'b10;
            2'd3:    led_map = fast ? 2'b10 : 2'b01;
            default: led_map = 2'b11;
        endcase
    endfunction

    // A press landing on the terminal count wins: mode change, no tick.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mode <= IDLE;
            cnt  <= '0;
            step <= '0;
            tick <= 1'b0;
            led  <= 2'b11;
        end else if (mode_chg) begin
            mode <= mode_nxt;
            cnt  <= '0;
            step <= '0;
            tick <= 1'b0;
            led  <= 2'b11;
        end else if (mode == IDLE) begin
            cnt  <= '0;
            step <= '0;
            tick <= 1'b0;
            led  <= 2'b11;
        end else if (hold) begin
            tick <= 1'b0;
        end else if (cnt == last) begin
            cnt  <= '0;
            tick <= 1'b1;
            step <= step_inc;
            led  <= led_map(mode == FAST, step_inc);
        end else begin
            cnt  <= cnt + 31'd1;
            tick <= 1'b0;
        end
    end

    assign io.LED  = led;
    assign io.mode = mode;
    assign io.step = step;
    assign io.tick = tick;
endmodule

// File: tb/tb_led_rate_sched.sv
// Randomized bench for led_rate_sched: a reference model predicts mode changes and ticks,
// a monitor matches them against what the DUT presents.
module tb_led_rate_sched;
    localparam int SLOW_DIV = 8;
    localparam int FAST_DIV = 4;
    localparam int DB       = 3;

    logic clk = 1'b0;
    logic rst = 1'b0;

    led_rate_sched_if io();

    led_rate_sched #(.SLOW_DIV(SLOW_DIV), .FAST_DIV(FAST_DIV), .DB_CYCLES(DB)) dut (
        .clk (clk),
        .rst (rst),
        .io  (io.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        int e;
        int mode;
        int step;
        int led;
    } ev_t;

    ev_t tq[$];
    ev_t mq[$];
    int  ecnt = 0;
    int  vectors = 0;
    int  errors = 0;

    // next mode by [current mode][button], button 0 = PB1
    int nxt_tab[3][2] = '{'{1, 2}, '{0, 2}, '{1, 0}};
    // LED by [mode][step]
    int led_tab[3][4] = '{'{3, 3, 3, 3}, '{3, 0, 2, 1}, '{3, 0, 1, 2}};

    task automatic chk(input string name, input int act, input int exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", name, act, exp, ecnt);
        end
    endtask

    // Reference model: debounce as a sample window, divider as elapsed active cycles.
    initial begin : model
        bit  p1[2], p2[2], db[2], pend[2];
        bit  hist[2][$];
        bit  x, flip, hw;
        int  mode_m, el, div, s;
        ev_t ev;
        forever begin
            @(posedge clk or negedge rst);
            if (!rst) begin
                for (int b = 0; b < 2; b++) begin
                    p1[b] = 1'b1; p2[b] = 1'b1; db[b] = 1'b1; pend[b] = 1'b0;
                    hist[b].delete();
                end
                mode_m = 0;
                el = 0;
                tq.delete();
                mq.delete();
            end else begin
                ecnt++;
`ifdef LED_SCHED_HOLD_EN
                hw = io.hold;
`else
                hw = 1'b0;
`endif
                if (pend[0] || pend[1]) begin
                    mode_m = nxt_tab[mode_m][pend[0] ? 0 : 1];
                    el = 0;
                    ev.e = ecnt; ev.mode = mode_m; ev.step = 0; ev.led = 3;
                    mq.push_back(ev);
                end else if (mode_m != 0 && !hw) begin
                    el++;
                    div = (mode_m == 1) ? SLOW_DIV : FAST_DIV;
                    if (el % div == 0) begin
                        s = (el / div) % 4;
                        ev.e = ecnt; ev.mode = mode_m; ev.step = s; ev.led = led_tab[mode_m][s];
                        tq.push_back(ev);
                    end
                end
                for (int b = 0; b < 2; b++) begin
                    x = p2[b];
                    p2[b] = p1[b];
                    p1[b] = (b == 0) ? io.PB1 : io.PB2;
                    hist[b].push_back(x);
                    if (hist[b].size() > DB) void'(hist[b].pop_front());
                    flip = (hist[b].size() == DB);
                    foreach (hist[b][i]) if (hist[b][i] == db[b]) flip = 1'b0;
                    pend[b] = 1'b0;
                    if (flip) begin
                        pend[b] = db[b];
                        db[b] = !db[b];
                        hist[b].delete();
                    end
                end
            end
        end
    end

    initial begin : monitor
        int  prev;
        ev_t ev;
        prev = 0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                prev = 0;
                chk("reset outputs", {io.mode, io.step, io.LED, io.tick}, {2'd0, 2'd0, 2'b11, 1'b0});
            end else begin
                while (tq.size() > 0 && tq[0].e < ecnt) begin
                    ev = tq.pop_front();
                    vectors++; errors++;
                    $display("FAIL missing tick: expected tick=1 at edge %0d, got tick=0", ev.e);
                end
                while (mq.size() > 0 && mq[0].e < ecnt) begin
                    ev = mq.pop_front();
                    vectors++; errors++;
                    $display("FAIL missing mode change: mode %0d, required mode %0d at edge %0d", io.mode, ev.mode, ev.e);
                end
                if (io.tick) begin
                    if (tq.size() == 0) begin
                        vectors++; errors++;
                        $display("FAIL unexpected tick: got tick=1 at edge %0d, required 0", ecnt);
                    end else begin
                        ev = tq.pop_front();
                        chk("tick edge", ecnt, ev.e);
                        chk("tick step", io.step, ev.step);
                        chk("tick LED", io.LED, ev.led);
                        chk("tick mode", io.mode, ev.mode);
                    end
                end
                if (io.mode != prev) begin
                    if (mq.size() == 0) begin
                        vectors++; errors++;
                        $display("FAIL unexpected mode change: got %0d, required %0d", io.mode, prev);
                    end else begin
                        ev = mq.pop_front();
                        chk("mode edge", ecnt, ev.e);
                        chk("mode value", io.mode, ev.mode);
                        chk("mode-change LED", io.LED, 3);
                        chk("mode-change step", io.step, 0);
                        chk("mode-change tick", io.tick, 0);
                    end
                end
                prev = io.mode;
            end
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic press(input bit b1, input bit b2, input int len);
        @(negedge clk);
        if (b1) io.PB1 = 1'b0;
        if (b2) io.PB2 = 1'b0;
        cyc(len);
        io.PB1 = 1'b1;
        io.PB2 = 1'b1;
    endtask

    initial begin : stim
        io.PB1 = 1'b1;
        io.PB2 = 1'b1;
`ifdef LED_SCHED_HOLD_EN
        io.hold = 1'b0;
`endif
        cyc(3);
        rst = 1'b1;

        cyc(50);
        chk("idle LED", io.LED, 3);
        chk("idle mode", io.mode, 0);
        chk("idle step", io.step, 0);

        press(1, 0, 20); cyc(45);
        chk("after PB1 mode", io.mode, 1);
        press(0, 1, 10); cyc(25);
        chk("after PB2 mode", io.mode, 2);
        press(0, 1, 2);  cyc(20);
        chk("glitch mode", io.mode, 2);
        press(0, 1, 8);  cyc(10);
        chk("FAST toggle-off mode", io.mode, 0);
        chk("FAST toggle-off LED", io.LED, 3);
        press(1, 1, 10); cyc(10);
        chk("simultaneous press mode", io.mode, 1);
        press(0, 1, 6);  cyc(9);

        @(posedge clk);
        #2 rst = 1'b0;
        #1 chk("async reset", {io.mode, io.step, io.LED, io.tick}, {2'd0, 2'd0, 2'b11, 1'b0});
        cyc(3);
        rst = 1'b1;
        cyc(30);
        chk("post-reset mode", io.mode, 0);

`ifdef LED_SCHED_HOLD_EN
        press(1, 0, 6); cyc(5);
        io.hold = 1'b1; cyc(20);
        chk("held LED", io.LED, 3);
        io.hold = 1'b0; cyc(30);
        press(1, 0, 6); cyc(10);
`endif

        repeat (40) begin
            case ($urandom_range(0, 4))
                0: press(1, 0, $urandom_range(1, 8));
                1: press(0, 1, $urandom_range(1, 8));
                2: press(1, 1, $urandom_range(1, 8));
`ifdef LED_SCHED_HOLD_EN
                3: io.hold = ~io.hold;
`endif
                default: ;
            endcase
            cyc($urandom_range(1, 30));
        end

`ifdef LED_SCHED_HOLD_EN
        io.hold = 1'b0;
`endif
        cyc(20);
        chk("leftover ticks", tq.size(), 0);
        chk("leftover mode changes", mq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule

// File: doc/led_rate_sched.md
Name: led_rate_sched

Overview:
- Controller and sequencer for the 2-bit LED pattern engine on the 50 MHz board clock.
- Debounces the two active-low pushbuttons and arbitrates them into a single mode: IDLE, SLOW or FAST.
- Generates the step tick and drives the LED pattern for the selected rate.
- Replaces ad-hoc button polling inside pattern logic; sits between the board buttons and the LED pins.

Parameters:
- SLOW_DIV, 50000000: clock cycles per step in SLOW mode (1 s at 50 MHz); legal range 2..2^31-1.
- FAST_DIV, 25000000: clock cycles per step in FAST mode (0.5 s); legal range 2..2^31-1.
- DB_CYCLES, 1000000: consecutive stable samples required to accept a button level (20 ms); minimum 1.

Ports:
- clk  in  1  board clock.
- rst  in  1  asynchronous reset, active-low; one clock domain only.
- PB1  in  1  pushbutton 1, active-low, asynchronous to clk.
- PB2  in  1  pushbutton 2, active-low, asynchronous to clk.
- LED  out  2  LED pattern, active-low (2'b11 = all off).
- mode  out  2  current mode: 2'd0 IDLE, 2'd1 SLOW, 2'd2 FAST; 2'd3 never driven.
- step  out  2  current pattern step index, 0..3.
- tick  out  1  one-cycle pulse on each step advance.

Behaviour:
- Reset (rst=0, asynchronous): mode=IDLE, LED=2'b11, step=0, tick=0, divider count=0.
  - Debounced button levels reset to 1 (released); synchronizer flops reset to 1.
- Input path:
  - Each PB passes through a 2-flop synchronizer, then a debounce counter.
  - The debounced level changes only after DB_CYCLES consecutive synchronized samples that differ from the current debounced level.
  - Any mismatching-back sample clears the counter.
- Press event: a debounced 1->0 transition, one cycle wide. Release generates nothing. A held button produces exactly one event.
- Arbitration: press events on PB1 and PB2 in the same cycle resolve to PB1 only; the PB2 event is discarded.
- FSM transitions, evaluated on the cycle of the press event:
  - IDLE: PB1 -> SLOW, PB2 -> FAST.
  - SLOW: PB2 -> FAST; PB1 -> IDLE (toggle off).
  - FAST: PB1 -> SLOW; PB2 -> IDLE (toggle off).
- On every mode change, on the same edge: divider count=0, step=0, tick=0, LED=2'b11.
- Divider, active in SLOW/FAST only; DIV is SLOW_DIV or FAST_DIV per mode:
  - Count increments each cycle.
  - When count==DIV-1: count->0, tick=1 for one cycle, step->step+1 mod 4, LED updated on the same edge.
  - First tick occurs DIV cycles after the mode-change edge.
- LED mapping by post-increment step:
  - SLOW: 1->2'b00, 2->2'b10, 3->2'b01, 0->2'b11.
  - FAST: 1->2'b00, 2->2'b01, 3->2'b10, 0->2'b11.
- IDLE: count held at 0, LED=2'b11, step=0, tick=0.
- A press event arriving in the same cycle as a terminal count wins: the mode change applies and no tick is issued.
- Divider counter is 31 bits; no other arithmetic; step wraps 3->0.
- Reset asserted mid-operation returns everything to reset values immediately (asynchronously). Operation resumes only via new press events after release of rst.

Optional Feature:
- Macro: LED_SCHED_HOLD_EN.
- When defined:
  - Adds input port `hold` (1 bit, synchronous, active-high).
  - While hold=1 in SLOW/FAST: divider count, step and LED freeze and tick=0.
  - Press events are still processed while held, and a mode change still clears count and step.
  - Deasserting hold resumes counting from the frozen count.
- When undefined: no `hold` port; behaviour exactly as above.

Test Plan:
All scenarios use SLOW_DIV=8, FAST_DIV=4, DB_CYCLES=3.
- Reset then idle 50 cycles, no presses -> LED=2'b11, mode=0, step=0, tick never 1.
- PB1 low held 20 cycles -> exactly one event; mode=1; ticks every 8 cycles; LED sequence 00,10,01,11,00.
- PB2 pressed while in SLOW -> mode=2 on event cycle, LED=2'b11, step=0; next ticks every 4 cycles; LED 00,01,10,11.
- PB2 glitch: low for 2 cycles, then high -> no event; mode unchanged.
- PB1 and PB2 low on the same cycle, both held 10 cycles -> mode=1 only.
- PB2 press while in FAST -> mode=0, LED=2'b11.
- rst pulsed low mid-step while in FAST -> outputs at reset values within the same cycle; no ticks until a new press.
- With LED_SCHED_HOLD_EN: hold=1 for 20 cycles at count 5 in SLOW -> no tick and LED stable; after hold drops, next tick arrives 3 cycles later.
